// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, baud divisor helper and board defaults.
package uart_pkg;

    // Board clock and line rate shared by the RX front end and the future TX stage.
    localparam int unsigned CLK_HZ_DEFAULT = 25_000_000;
    localparam int unsigned BAUD_DEFAULT   = 115_200;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_rx_state_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO: o_data always presents the head entry.
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [7:0]                 i_data,
    input  logic                       i_pop,
    output logic [7:0]                 o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_COUNT);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // A pop on an empty FIFO is ignored; a push while full only lands if a pop frees a slot.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage, pointers and occupancy; memory resets to zero so the head reads 8'h00.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with input synchroniser, feeding a show-ahead byte FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
    parameter int unsigned BAUD       = BAUD_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          pll_clk,
    input  logic                          rst,
    input  logic                          rx_pin,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD  = CW'(CLKS_PER_BIT - 1);

    logic [1:0]     r_sync;
    logic           w_rx_s;
    uart_rx_state_t r_state, w_state_d;
    logic [CW-1:0]  r_cnt, w_cnt_d;
    logic [2:0]     r_bit_idx, w_bit_idx_d;
    logic [7:0]     r_shift, w_shift_d;
    logic           r_frame_err, w_frame_err_d;
    logic           r_overflow, w_overflow_d;
    logic           w_expire;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;

    assign w_rx_s   = r_sync[1];
    assign w_expire = (r_cnt == '0);
    assign w_pop    = ready_i && !w_empty;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge pll_clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_pin};
        end
    end

    // Receive FSM and datapath registers.
    always_ff @(posedge pll_clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_bit_idx   <= w_bit_idx_d;
            r_shift     <= w_shift_d;
            r_frame_err <= w_frame_err_d;
            r_overflow  <= w_overflow_d;
        end
    end

    // Next-state logic: mid-bit sampling driven by a down-counter that expires at zero.
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_bit_idx_d   = r_bit_idx;
        w_shift_d     = r_shift;
        w_push        = 1'b0;
        w_frame_err_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_rx_s) begin
                    w_cnt_d   = HALF_LOAD;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (!w_expire) begin
                    w_cnt_d = r_cnt - CW'(1);
                end else if (w_rx_s) begin
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d     = FULL_LOAD;
                    w_bit_idx_d = '0;
                    w_state_d   = StData;
                end
            end
            StData: begin
                if (!w_expire) begin
                    w_cnt_d = r_cnt - CW'(1);
                end else begin
                    w_shift_d = {w_rx_s, r_shift[7:1]};
                    w_cnt_d   = FULL_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_d = StStop;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 3'd1;
                    end
                end
            end
            StStop: begin
                if (!w_expire) begin
                    w_cnt_d = r_cnt - CW'(1);
                end else if (w_rx_s) begin
                    w_push    = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_frame_err_d = 1'b1;
                    w_state_d     = StBreak;
                end
            end
            StBreak: begin
                // Hold here until the line returns high so a stuck-low line yields one error.
                if (w_rx_s) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        w_overflow_d = w_push && w_full && !w_pop;
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (pll_clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (w_shift_d),
        .i_pop   (ready_i),
        .o_data  (data_o),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count_o)
    );

    assign valid_o     = !w_empty;
    assign frame_err_o = r_frame_err;
    assign overflow_o  = r_overflow;

endmodule
